te_block_builder: RTL and testbench



---
 rtl/mure_pkg.sv | 36 +++
 rtl/te_block_builder.sv | 148 ++++++++++++++
 tb/tb_te_block_builder.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mure_pkg.sv
// Shared trace types: instruction itype codes and the block record handed to the packetiser.
// Latency: n/a (types only).
// Backpressure: n/a.
package mure_pkg;

  localparam int ITYPE_LEN      = 4;
  localparam int TE_XLEN        = 64;
  localparam int TE_IRETIRE_LEN = 32;
  localparam int TE_CAUSE_LEN   = 5;

  typedef enum logic [ITYPE_LEN-1:0] {
    STD  = 4'd0,
    EXC  = 4'd1,
    INT  = 4'd2,
    ERET = 4'd3,
    NTB  = 4'd4,
    TB   = 4'd5,
    UIJ  = 4'd8,
    IJ   = 4'd9
  } itype_e;

  // Block record; fields are sized for the widest supported configuration.
  typedef struct packed {
    logic [TE_XLEN-1:0]        iaddr;
    logic [TE_IRETIRE_LEN-1:0] iretire;
    logic                      ilastsize;
    itype_e                    itype;
    logic [TE_CAUSE_LEN-1:0]   cause;
    logic [TE_XLEN-1:0]        tval;
  } te_block_t;

  function automatic logic is_trap(input itype_e t);
    return (t == EXC) || (t == INT);
  endfunction

endpackage

// File: rtl/te_block_builder.sv
// Groups classified commits into E-Trace instruction blocks and emits one record per block.
// Latency: block record visible 1 cycle after the closing commit or flush is accepted.
// Backpressure: ready_o = !block_valid_o || block_ready_i; commits and flush stall while the output is held.
module te_block_builder
  import mure_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int IRETIRE_LEN = 32,
  parameter int CAUSE_LEN   = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  itype_e                 itype_i,
  input  logic [XLEN-1:0]        pc_i,
  input  logic                   compressed_i,
  input  logic [CAUSE_LEN-1:0]   cause_i,
  input  logic [XLEN-1:0]        tval_i,
  input  logic                   flush_i,
  output logic                   block_valid_o,
  input  logic                   block_ready_i,
  output logic [XLEN-1:0]        iaddr_o,
  output logic [IRETIRE_LEN-1:0] iretire_o,
  output logic                   ilastsize_o,
  output itype_e                 itype_o,
  output logic [CAUSE_LEN-1:0]   cause_o,
  output logic [XLEN-1:0]        tval_o
);

  typedef enum logic {IDLE, ACCUM} bb_state_e;

  // Largest count that still leaves room for one more 32-bit instruction.
  localparam logic [IRETIRE_LEN-1:0] CNT_LIMIT = {IRETIRE_LEN{1'b1}} - IRETIRE_LEN'(2);

  bb_state_e              state_q, state_d;
  logic [XLEN-1:0]        start_q, start_d;
  logic [IRETIRE_LEN-1:0] count_q, count_d;
  logic                   last_q, last_d;
  logic                   blk_vld_q, blk_vld_d;
  te_block_t              blk_q, blk_d;

  logic                   open;
  logic                   commit_acc;
  logic                   flush_acc;
  logic [IRETIRE_LEN-1:0] sz;
  logic [XLEN-1:0]        start_n;
  logic [IRETIRE_LEN-1:0] cnt_n;
  logic                   last_n;
  logic                   close_n;
  logic                   emit;
  te_block_t              emit_blk;

  assign ready_o    = !blk_vld_q || block_ready_i;
  assign open       = (state_q == ACCUM);
  assign commit_acc = valid_i && ready_o;
  // Flush is only honoured when a block could be emitted this cycle.
  assign flush_acc  = flush_i && ready_o;

  // Block contents as they would look after folding in the current (non-trap) commit.
  assign sz      = compressed_i ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
  assign start_n = open ? start_q : pc_i;
  assign cnt_n   = (open ? count_q : '0) + sz;
  assign last_n  = !compressed_i;
  assign close_n = (itype_i != STD) || (cnt_n > CNT_LIMIT);

  // Next-state: accumulate commits, decide on block close, manage the output register.
  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    count_d   = count_q;
    last_d    = last_q;
    blk_vld_d = blk_vld_q;
    blk_d     = blk_q;
    emit      = 1'b0;
    emit_blk  = '0;

    if (commit_acc) begin
      if (is_trap(itype_i)) begin
        // Trapping instruction did not retire, so it closes the block without being counted.
        emit               = 1'b1;
        emit_blk.iaddr     = TE_XLEN'(open ? start_q : pc_i);
        emit_blk.iretire   = TE_IRETIRE_LEN'(open ? count_q : '0);
        emit_blk.ilastsize = open ? last_q : 1'b0;
        emit_blk.itype     = itype_i;
        emit_blk.cause     = TE_CAUSE_LEN'(cause_i);
        emit_blk.tval      = TE_XLEN'(tval_i);
        state_d            = IDLE;
      end else if (close_n || flush_acc) begin
        // itype_i is STD whenever the close came from the counter limit or flush alone.
        emit               = 1'b1;
        emit_blk.iaddr     = TE_XLEN'(start_n);
        emit_blk.iretire   = TE_IRETIRE_LEN'(cnt_n);
        emit_blk.ilastsize = last_n;
        emit_blk.itype     = itype_i;
        state_d            = IDLE;
      end else begin
        state_d = ACCUM;
        start_d = start_n;
        count_d = cnt_n;
        last_d  = last_n;
      end
    end else if (flush_acc && open) begin
      emit               = 1'b1;
      emit_blk.iaddr     = TE_XLEN'(start_q);
      emit_blk.iretire   = TE_IRETIRE_LEN'(count_q);
      emit_blk.ilastsize = last_q;
      emit_blk.itype     = STD;
      state_d            = IDLE;
    end

    // A new emit overwrites the register even when it drains in the same cycle.
    if (emit) begin
      blk_vld_d = 1'b1;
      blk_d     = emit_blk;
    end else if (block_ready_i) begin
      blk_vld_d = 1'b0;
    end
  end

  // State and output register; reset drops any open block and pending record.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      start_q   <= '0;
      count_q   <= '0;
      last_q    <= 1'b0;
      blk_vld_q <= 1'b0;
      blk_q     <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      count_q   <= count_d;
      last_q    <= last_d;
      blk_vld_q <= blk_vld_d;
      blk_q     <= blk_d;
    end
  end

  assign block_valid_o = blk_vld_q;
  assign iaddr_o       = blk_q.iaddr[XLEN-1:0];
  assign iretire_o     = blk_q.iretire[IRETIRE_LEN-1:0];
  assign ilastsize_o   = blk_q.ilastsize;
  assign itype_o       = blk_q.itype;
  assign cause_o       = blk_q.cause[CAUSE_LEN-1:0];
  assign tval_o        = blk_q.tval[XLEN-1:0];

endmodule

// File: tb/tb_te_block_builder.sv
// Bench for te_block_builder: directed vector table plus randomized run against a queue-based model.
// Latency: checks block outputs one cycle after each accepted commit.
// Backpressure: exercises block_ready_i stalls both directed and random.
module tb_te_block_builder;
  import mure_pkg::*;

  localparam int XLEN = 64;
  localparam int IRL  = 4;
  localparam int CL   = 5;
  localparam int LIMIT = (1 << IRL) - 3;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            valid_i;
  logic            ready_o;
  itype_e          itype_i;
  logic [XLEN-1:0] pc_i;
  logic            compressed_i;
  logic [CL-1:0]   cause_i;
  logic [XLEN-1:0] tval_i;
  logic            flush_i;
  logic            block_valid_o;
  logic            block_ready_i;
  logic [XLEN-1:0] iaddr_o;
  logic [IRL-1:0]  iretire_o;
  logic            ilastsize_o;
  itype_e          itype_o;
  logic [CL-1:0]   cause_o;
  logic [XLEN-1:0] tval_o;

  always #5 clk = ~clk;

  te_block_builder #(.XLEN(XLEN), .IRETIRE_LEN(IRL), .CAUSE_LEN(CL)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .itype_i(itype_i), .pc_i(pc_i), .compressed_i(compressed_i),
    .cause_i(cause_i), .tval_i(tval_i), .flush_i(flush_i),
    .block_valid_o(block_valid_o), .block_ready_i(block_ready_i),
    .iaddr_o(iaddr_o), .iretire_o(iretire_o), .ilastsize_o(ilastsize_o),
    .itype_o(itype_o), .cause_o(cause_o), .tval_o(tval_o)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: open block kept as a list of instruction sizes
  bit        m_open;
  bit [63:0] m_start;
  int        m_sizes[$];
  bit        m_vld;
  te_block_t m_blk;

  function automatic int qsum();
    int s = 0;
    foreach (m_sizes[i]) s += m_sizes[i];
    return s;
  endfunction

  function automatic bit qlast32();
    return (m_sizes.size() != 0) && (m_sizes[m_sizes.size()-1] == 2);
  endfunction

  task automatic model_clk();
    te_block_t nb;
    bit emit;
    bit rdy;
    if (rst_i) begin
      m_open = 0; m_sizes.delete(); m_vld = 0; m_blk = '0;
      return;
    end
    rdy  = !m_vld || block_ready_i;
    nb   = '0;
    emit = 0;
    if (valid_i && rdy) begin
      if (itype_i == EXC || itype_i == INT) begin
        nb.iaddr     = m_open ? m_start : pc_i;
        nb.iretire   = m_open ? qsum() : 0;
        nb.ilastsize = m_open ? qlast32() : 1'b0;
        nb.itype     = itype_i;
        nb.cause     = cause_i;
        nb.tval      = tval_i;
        emit = 1; m_open = 0; m_sizes.delete();
      end else begin
        if (!m_open) m_start = pc_i;
        m_open = 1;
        m_sizes.push_back(compressed_i ? 1 : 2);
        if (itype_i != STD || qsum() > LIMIT || flush_i) begin
          nb.iaddr = m_start; nb.iretire = qsum(); nb.ilastsize = qlast32(); nb.itype = itype_i;
          emit = 1; m_open = 0; m_sizes.delete();
        end
      end
    end else if (flush_i && rdy && m_open) begin
      nb.iaddr = m_start; nb.iretire = qsum(); nb.ilastsize = qlast32(); nb.itype = STD;
      emit = 1; m_open = 0; m_sizes.delete();
    end
    if (emit) begin
      m_vld = 1; m_blk = nb;
    end else if (block_ready_i) begin
      m_vld = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_clk();
    @(negedge clk);
  endtask

  // ---------------- directed vectors
  typedef struct {
    bit        rst, vld, cmp, fl, brdy;
    itype_e    it;
    bit [63:0] pc;
    bit [4:0]  cause;
    bit [63:0] tval;
    bit        e_rdy, e_bvld, e_chk;
    bit [63:0] e_addr;
    bit [3:0]  e_cnt;
    bit        e_last;
    itype_e    e_it;
    bit [4:0]  e_cause;
    bit [63:0] e_tval;
  } vec_t;

  vec_t vecs[$];

  // Row without an emitted block (reset rows also check all fields are zero).
  task automatic nb(bit rst, bit vld, itype_e it, bit [63:0] pc, bit cmp, bit fl, bit brdy, bit erdy);
    vec_t v;
    v = '{rst:rst, vld:vld, cmp:cmp, fl:fl, brdy:brdy, it:it, pc:pc, cause:5'h1F, tval:64'hBAD,
          e_rdy:erdy, e_bvld:0, e_chk:rst, e_addr:0, e_cnt:0, e_last:0, e_it:STD, e_cause:0, e_tval:0};
    vecs.push_back(v);
  endtask

  // Row after which a block must be on the outputs.
  task automatic eb(bit vld, itype_e it, bit [63:0] pc, bit cmp, bit fl, bit brdy, bit erdy,
                    bit [63:0] a, bit [3:0] c, bit l, itype_e eit, bit [4:0] ec, bit [63:0] et);
    vec_t v;
    bit trap;
    trap = (it == EXC || it == INT);
    v = '{rst:0, vld:vld, cmp:cmp, fl:fl, brdy:brdy, it:it, pc:pc,
          cause:trap ? ec : 5'h1F, tval:trap ? et : 64'hBAD,
          e_rdy:erdy, e_bvld:1, e_chk:1, e_addr:a, e_cnt:c, e_last:l, e_it:eit, e_cause:ec, e_tval:et};
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int idx);
    string s;
    rst_i = v.rst; valid_i = v.vld; itype_i = v.it; pc_i = v.pc; compressed_i = v.cmp;
    cause_i = v.cause; tval_i = v.tval; flush_i = v.fl; block_ready_i = v.brdy;
    #1;
    s = $sformatf("vec%0d", idx);
    chk({s, ".ready"}, 64'(ready_o), 64'(v.e_rdy));
    step();
    chk({s, ".bvld"}, 64'(block_valid_o), 64'(v.e_bvld));
    if (v.e_chk) begin
      chk({s, ".iaddr"}, iaddr_o, v.e_addr);
      chk({s, ".iretire"}, 64'(iretire_o), 64'(v.e_cnt));
      chk({s, ".ilast"}, 64'(ilastsize_o), 64'(v.e_last));
      chk({s, ".itype"}, 64'(itype_o), 64'(v.e_it));
      chk({s, ".cause"}, 64'(cause_o), 64'(v.e_cause));
      chk({s, ".tval"}, tval_o, v.e_tval);
    end
  endtask

  itype_e pick[8] = '{STD, EXC, INT, ERET, NTB, TB, UIJ, IJ};

  initial begin
    rst_i = 1; valid_i = 0; itype_i = STD; pc_i = 0; compressed_i = 0;
    cause_i = 0; tval_i = 0; flush_i = 0; block_ready_i = 1;
    @(negedge clk);

    nb(1, 0, STD, 64'h0, 0, 0, 1, 1);                          // reset values
    // three STD then TB
    nb(0, 1, STD, 64'h100, 0, 0, 1, 1);
    nb(0, 1, STD, 64'h104, 1, 0, 1, 1);
    nb(0, 1, STD, 64'h106, 0, 0, 1, 1);
    eb(1, TB, 64'h10A, 0, 0, 1, 1, 64'h100, 7, 1, TB, 0, 0);
    nb(0, 0, STD, 64'h0, 0, 0, 1, 1);
    // exception from IDLE, then a fresh block
    eb(1, EXC, 64'h200, 0, 0, 1, 1, 64'h200, 0, 0, EXC, 5'd2, 64'hDEAD);
    nb(0, 1, STD, 64'h300, 0, 0, 1, 1);
    eb(1, TB, 64'h304, 1, 0, 1, 1, 64'h300, 3, 0, TB, 0, 0);
    // counter limit: seven 32-bit commits close at count 14
    for (int i = 0; i < 6; i++) nb(0, 1, STD, 64'(4 * i), 0, 0, 1, 1);
    eb(1, STD, 64'h18, 0, 0, 1, 1, 64'h0, 14, 1, STD, 0, 0);
    nb(0, 1, STD, 64'h1C, 0, 0, 1, 1);
    eb(1, TB, 64'h20, 0, 0, 1, 1, 64'h1C, 4, 1, TB, 0, 0);
    // flush alone, flush with commit, flush in IDLE
    nb(0, 1, STD, 64'h40, 1, 0, 1, 1);
    nb(0, 1, STD, 64'h42, 1, 0, 1, 1);
    eb(0, STD, 64'h0, 0, 1, 1, 1, 64'h40, 2, 0, STD, 0, 0);
    nb(0, 1, STD, 64'h40, 1, 0, 1, 1);
    nb(0, 1, STD, 64'h42, 1, 0, 1, 1);
    eb(1, STD, 64'h44, 0, 1, 1, 1, 64'h40, 4, 1, STD, 0, 0);
    nb(0, 0, STD, 64'h0, 0, 1, 1, 1);
    // backpressure: five cycles held, stalled commit not counted
    nb(0, 1, STD, 64'h60, 0, 0, 1, 1);
    eb(1, TB, 64'h64, 0, 0, 0, 1, 64'h60, 4, 1, TB, 0, 0);
    for (int i = 0; i < 4; i++) eb(1, STD, 64'h70, 0, 1, 0, 0, 64'h60, 4, 1, TB, 0, 0);
    nb(0, 1, STD, 64'h70, 0, 0, 1, 1);
    eb(1, TB, 64'h74, 1, 0, 1, 1, 64'h70, 3, 0, TB, 0, 0);
    // reset with an open block of count 6
    nb(0, 1, STD, 64'h80, 0, 0, 1, 1);
    nb(0, 1, STD, 64'h84, 0, 0, 1, 1);
    nb(0, 1, STD, 64'h88, 0, 0, 1, 1);
    nb(1, 0, STD, 64'h0, 0, 0, 1, 1);
    nb(0, 1, STD, 64'h500, 0, 0, 1, 1);
    eb(1, TB, 64'h504, 0, 0, 1, 1, 64'h500, 4, 1, TB, 0, 0);
    // back-to-back single-instruction blocks
    eb(1, TB, 64'h600, 1, 0, 1, 1, 64'h600, 1, 0, TB, 0, 0);
    eb(1, TB, 64'h602, 0, 0, 1, 1, 64'h602, 2, 1, TB, 0, 0);

    foreach (vecs[i]) apply(vecs[i], i);

    // ---------------- randomized run against the model
    rst_i = 1; valid_i = 0; flush_i = 0; block_ready_i = 1;
    step();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int r;
      rst_i         = ($urandom_range(0, 199) == 0);
      valid_i       = ($urandom_range(0, 9) < 8);
      r             = $urandom_range(0, 19);
      itype_i       = (r < 13) ? STD : pick[$urandom_range(1, 7)];
      pc_i          = {$urandom(), $urandom()} & ~64'h1;
      compressed_i  = $urandom_range(0, 1);
      cause_i       = CL'($urandom());
      tval_i        = {$urandom(), $urandom()};
      flush_i       = ($urandom_range(0, 19) == 0);
      block_ready_i = ($urandom_range(0, 9) < 7);
      #1;
      if (!rst_i) chk("rnd.ready", 64'(ready_o), 64'(!m_vld || block_ready_i));
      step();
      chk("rnd.bvld", 64'(block_valid_o), 64'(m_vld));
      if (m_vld) begin
        chk("rnd.iaddr", iaddr_o, m_blk.iaddr);
        chk("rnd.iretire", 64'(iretire_o), 64'(m_blk.iretire));
        chk("rnd.ilast", 64'(ilastsize_o), 64'(m_blk.ilastsize));
        chk("rnd.itype", 64'(itype_o), 64'(m_blk.itype));
        chk("rnd.cause", 64'(cause_o), 64'(m_blk.cause));
        chk("rnd.tval", tval_o, m_blk.tval);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
